// File: rtl/btb_predictor_if.sv
// Bus between the fetch/execute pipeline and the branch target buffer.
// master: pipeline side (drives lookup PC and resolved-branch updates).
// slave : BTB side (returns the combinational prediction).
interface btb_predictor_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] current_pc;
    logic            tag_match;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            update_valid;
    logic [PC_W-1:0] update_pc;
    logic [PC_W-1:0] update_target;
    logic            update_taken;
    logic            flush;

    modport master (
        output current_pc, update_valid, update_pc, update_target, update_taken, flush,
        input  tag_match, pred_taken, pred_target
    );

    modport slave (
        input  current_pc, update_valid, update_pc, update_target, update_taken, flush,
        output tag_match, pred_taken, pred_target
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry valid bits and saturating
// direction counters. Lookup is combinational on current_pc; resolved branches
// train or allocate entries at the clock edge. Taken branches allocate on a miss,
// not-taken branches never allocate. flush invalidates every entry but keeps
// counters and targets.
// Optional build macro BTB_PERF_CNT_EN adds saturating lookup/hit/mispredict
// counters on extra output ports.
module btb_predictor #(
    parameter int ENTRIES = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    btb_predictor_if.slave     bus
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_lookups,
    output logic [31:0]        perf_hits,
    output logic [31:0]        perf_mispred
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Counter encodings: MSB set means predict taken.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] WEAK_NT = WEAK_T - CNT_W'(1);

    // Flattened views of the per-entry state, used by the read-side muxes.
    logic [ENTRIES-1:0] valid_vec;
    logic [TAG_W-1:0]   tag_arr    [ENTRIES];
    logic [PC_W-1:0]    target_arr [ENTRIES];
    logic [CNT_W-1:0]   cnt_arr    [ENTRIES];

    // Lookup path (fetch side).
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx   = bus.current_pc[IDX_W+1:2];
    assign lk_tag   = bus.current_pc[PC_W-1:IDX_W+2];
    assign lk_hit   = valid_vec[lk_idx] && (tag_arr[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && cnt_arr[lk_idx][CNT_W-1];

    assign bus.tag_match   = lk_hit;
    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_taken ? target_arr[lk_idx] : bus.current_pc + PC_W'(4);

    // Update path (execute side). Flush suppresses any update in the same cycle.
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_write;

    assign upd_idx   = bus.update_pc[IDX_W+1:2];
    assign upd_tag   = bus.update_pc[PC_W-1:IDX_W+2];
    assign upd_hit   = valid_vec[upd_idx] && (tag_arr[upd_idx] == upd_tag);
    assign upd_write = bus.update_valid && !bus.flush;

    // The two low PC bits never affect indexing or tagging.
    logic unused_pc_low;
    assign unused_pc_low = ^{bus.current_pc[1:0], bus.update_pc[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [PC_W-1:0]  target_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             sel;

            assign sel = upd_write && (upd_idx == IDX_W'(gi));

            // Entry state: flush drops valid; a selected update trains a hit or allocates on a taken miss.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    cnt_reg    <= WEAK_NT;
                end else if (bus.flush) begin
                    valid_reg <= 1'b0;
                end else if (sel) begin
                    if (upd_hit) begin
                        if (bus.update_taken) begin
                            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
                            target_reg <= bus.update_target;
                        end else if (cnt_reg != '0) begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end else if (bus.update_taken) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= bus.update_target;
                        cnt_reg    <= WEAK_T;
                    end
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign tag_arr[gi]    = tag_reg;
            assign target_arr[gi] = target_reg;
            assign cnt_arr[gi]    = cnt_reg;
        end
    endgenerate

`ifdef BTB_PERF_CNT_EN
    logic [31:0] lookups_reg;
    logic [31:0] hits_reg;
    logic [31:0] mispred_reg;
    logic        upd_pred_taken;
    logic        upd_mispred;

    // What the table predicted for the resolving branch; a miss is a not-taken prediction.
    assign upd_pred_taken = upd_hit && cnt_arr[upd_idx][CNT_W-1];
    assign upd_mispred    = bus.update_valid &&
                            ((upd_pred_taken != bus.update_taken) ||
                             (upd_pred_taken && (target_arr[upd_idx] != bus.update_target)));

    // Saturating event counters; flush leaves them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookups_reg <= '0;
            hits_reg    <= '0;
            mispred_reg <= '0;
        end else begin
            if (lookups_reg != '1)               lookups_reg <= lookups_reg + 32'd1;
            if (lk_hit && hits_reg != '1)        hits_reg    <= hits_reg + 32'd1;
            if (upd_mispred && mispred_reg != '1) mispred_reg <= mispred_reg + 32'd1;
        end
    end

    assign perf_lookups = lookups_reg;
    assign perf_hits    = hits_reg;
    assign perf_mispred = mispred_reg;
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed cases plus randomized traffic. The driver
// pushes the expected prediction for each cycle into a queue; a monitor pops and
// compares at the falling edge. Expectations come from a reference model that
// stores whole branch PCs and uses integer counter arithmetic.
module tb_btb_predictor;
    localparam int ENTRIES = 32;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 5;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int WEAK_T  = 1 << (CNT_W - 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    btb_predictor_if #(.PC_W(PC_W)) bus ();

`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_lookups, perf_hits, perf_mispred;
`endif

    btb_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BTB_PERF_CNT_EN
        ,
        .perf_lookups (perf_lookups),
        .perf_hits    (perf_hits),
        .perf_mispred (perf_mispred)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        tm;
        logic        pt;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passes = 0;

    // Reference model: per index, the full PC of the branch held there.
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_pc[i]    = 0;
            m_tgt[i]   = 0;
            m_cnt[i]   = WEAK_T - 1;
        end
    endfunction

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit model_hit(logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && ((m_pc[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
    endfunction

    function automatic exp_t model_predict(string nm, logic [31:0] pc);
        exp_t e;
        int i = idx_of(pc);
        e.name = nm;
        e.pc   = pc;
        e.tm   = model_hit(pc);
        e.pt   = e.tm && (m_cnt[i] >= WEAK_T);
        e.tgt  = e.pt ? m_tgt[i] : pc + 32'd4;
        return e;
    endfunction

    function automatic void model_apply(bit uv, logic [31:0] upc, logic [31:0] utgt, bit ut, bit fl);
        int i = idx_of(upc);
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
        end else if (uv) begin
            if (model_hit(upc)) begin
                if (ut) begin
                    m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                    m_tgt[i] = utgt;
                end else begin
                    m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[i] = 1;
                m_pc[i]    = upc;
                m_tgt[i]   = utgt;
                m_cnt[i]   = WEAK_T;
            end
        end
    endfunction

    task automatic check_val(string nm, string what, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s %s: got 0x%08h expected 0x%08h", nm, what, act, req);
    endtask

    // Drive one cycle's inputs (no wait), queue the expectation, then advance the model.
    task automatic set_cycle(string nm, logic [31:0] pc, bit uv, logic [31:0] upc,
                             logic [31:0] utgt, bit ut, bit fl,
                             bit use_c, bit c_tm, bit c_pt, logic [31:0] c_tgt);
        exp_t e;
        bus.current_pc    = pc;
        bus.update_valid  = uv;
        bus.update_pc     = upc;
        bus.update_target = utgt;
        bus.update_taken  = ut;
        bus.flush         = fl;
        if (use_c) begin
            e.name = nm; e.pc = pc; e.tm = c_tm; e.pt = c_pt; e.tgt = c_tgt;
        end else begin
            e = model_predict(nm, pc);
        end
        exp_q.push_back(e);
        model_apply(uv, upc, utgt, ut, fl);
    endtask

    task automatic step(string nm, logic [31:0] pc, bit uv, logic [31:0] upc,
                        logic [31:0] utgt, bit ut, bit fl,
                        bit use_c, bit c_tm, bit c_pt, logic [31:0] c_tgt);
        @(posedge clk);
        #1;
        set_cycle(nm, pc, uv, upc, utgt, ut, fl, use_c, c_tm, c_pt, c_tgt);
    endtask

    // Directed lookup with constant expectations, optional update.
    task automatic dir(string nm, logic [31:0] pc, bit uv, logic [31:0] upc,
                       logic [31:0] utgt, bit ut, bit fl, bit tm, bit pt, logic [31:0] tgt);
        step(nm, pc, uv, upc, utgt, ut, fl, 1'b1, tm, pt, tgt);
    endtask

    task automatic idle_inputs();
        bus.current_pc = 0; bus.update_valid = 0; bus.update_pc = 0;
        bus.update_target = 0; bus.update_taken = 0; bus.flush = 0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [24:0] tags [4];
        logic [24:0] t;
        tags[0] = 25'h0; tags[1] = 25'h1; tags[2] = 25'h5; tags[3] = 25'h1FF_FFFF;
        t = tags[$urandom_range(0, 3)];
        return {t, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
    endfunction

    // Monitor: one comparison set per queued expectation, sampled at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %s pc=%08h tm=%0b pt=%0b tgt=%08h", e.name, e.pc,
                         bus.tag_match, bus.pred_taken, bus.pred_target);
                check_val(e.name, "tag_match",   {31'b0, bus.tag_match},  {31'b0, e.tm});
                check_val(e.name, "pred_taken",  {31'b0, bus.pred_taken}, {31'b0, e.pt});
                check_val(e.name, "pred_target", bus.pred_target,         e.tgt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and allocate-on-taken with no same-cycle bypass.
        set_cycle("reset_state", 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 32'h104);
        dir("alloc_cycle",  32'h100, 1, 32'h100, 32'h200, 1, 0, 0, 0, 32'h104);
        dir("alloc_seen",   32'h100, 0, 0, 0, 0, 0,             1, 1, 32'h200);
        // Counter walk: 2 -> 3 -> 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2.
        dir("walk_t",       32'h100, 1, 32'h100, 32'h200, 1, 0, 1, 1, 32'h200);
        dir("walk_nt3",     32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 1, 32'h200);
        dir("walk_nt2",     32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 1, 32'h200);
        dir("walk_nt1",     32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 0, 32'h104);
        dir("walk_nt0",     32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 0, 32'h104);
        dir("walk_t0",      32'h100, 1, 32'h100, 32'h200, 1, 0, 1, 0, 32'h104);
        dir("walk_t1",      32'h100, 1, 32'h100, 32'h200, 1, 0, 1, 0, 32'h104);
        dir("walk_t2",      32'h100, 1, 32'h100, 32'h200, 1, 0, 1, 1, 32'h200);
        dir("walk_t3",      32'h100, 1, 32'h100, 32'h208, 1, 0, 1, 1, 32'h200);
        dir("walk_sat",     32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 1, 32'h208);
        dir("walk_after",   32'h100, 0, 0, 0, 0, 0,             1, 1, 32'h208);
        // Aliasing eviction and no allocation for not-taken.
        dir("alias_upd",    32'h1080, 1, 32'h1080, 32'h40, 1, 0, 0, 0, 32'h1084);
        dir("alias_old",    32'h100,  0, 0, 0, 0, 0,            0, 0, 32'h104);
        dir("alias_new",    32'h1080, 0, 0, 0, 0, 0,            1, 1, 32'h40);
        dir("nt_noalloc_u", 32'h300,  1, 32'h300, 32'h500, 0, 0, 0, 0, 32'h304);
        dir("nt_noalloc",   32'h300,  0, 0, 0, 0, 0,            0, 0, 32'h304);
        // Flush wins over a same-cycle update.
        dir("flush_cycle",  32'h1080, 1, 32'h400, 32'h600, 1, 1, 1, 1, 32'h40);
        dir("flush_gone",   32'h1080, 0, 0, 0, 0, 0,            0, 0, 32'h1084);
        dir("flush_drop",   32'h400,  0, 0, 0, 0, 0,            0, 0, 32'h404);
        dir("pc_wrap",      32'hFFFF_FFFC, 0, 0, 0, 0, 0,       0, 0, 32'h0);
        // Async reset between edges.
        dir("pre_rst_alloc", 32'h20, 1, 32'h20, 32'h80, 1, 0,  0, 0, 32'h24);
        dir("pre_rst_hit",   32'h20, 0, 0, 0, 0, 0,            1, 1, 32'h80);
        @(posedge clk);
        #1;
        idle_inputs();
        bus.current_pc = 32'h20;
        #2 reset = 1'b1;
        model_reset();
        set_cycle("async_rst", 32'h20, 0, 0, 0, 0, 0, 1, 0, 0, 32'h24);
        @(posedge clk);
        #1 reset = 1'b0;
        set_cycle("post_rst", 32'h20, 0, 0, 0, 0, 0, 1, 0, 0, 32'h24);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step("rand", rand_pc(), 1'($urandom_range(0, 1)), rand_pc(), $urandom,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), 0, 0, 0, 0);
        end

        @(posedge clk);
        #1 idle_inputs();
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

`ifdef BTB_PERF_CNT_EN
        // 10 counted cycles: 4 hits, 2 mispredicts (taken miss, wrong target).
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1 reset = 1'b0;
        set_cycle("perf1", 32'h100, 1, 32'h100, 32'h200, 1, 0, 0, 0, 0, 0);
        step("perf2", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("perf3", 32'h100, 1, 32'h100, 32'h300, 1, 0, 0, 0, 0, 0);
        step("perf4", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("perf5", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step("perf_miss", 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_val("perf", "lookups", perf_lookups, 32'd10);
        check_val("perf", "hits",    perf_hits,    32'd4);
        check_val("perf", "mispred", perf_mispred, 32'd2);
        force dut.lookups_reg = 32'hFFFF_FFFF;
        force dut.hits_reg    = 32'hFFFF_FFFF;
        force dut.mispred_reg = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.lookups_reg;
        release dut.hits_reg;
        release dut.mispred_reg;
        set_cycle("perf_sat1", 32'h100, 1, 32'h100, 32'h900, 1, 0, 0, 0, 0, 0);
        step("perf_sat2", 32'h100, 1, 32'h100, 32'h0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        check_val("perf_sat", "lookups", perf_lookups, 32'hFFFF_FFFF);
        check_val("perf_sat", "hits",    perf_hits,    32'hFFFF_FFFF);
        check_val("perf_sat", "mispred", perf_mispred, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
